// File: rtl/in_port_pkg.sv
// Shared definitions for the CPU input-port controller and its FIFO.
package in_port_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/in_port_fifo.sv
// Word FIFO between the external device and the CPU bus.
// Occupancy is kept in a counter, and full/empty are derived from it.
// The head slot can be write-protected while the CPU is reading it.
module in_port_fifo #(
  parameter int DATA_W = in_port_pkg::DATA_W,
  parameter int DEPTH  = in_port_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_req,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop_req,
  input  logic                     protect_head,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  import in_port_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              head_hit;
  logic              push;
  logic              pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign head_data = mem[rd_ptr];

  // A write may only land on the head slot when the FIFO is full, and full
  // already blocks pushes. The extra guard keeps the held word safe anyway.
  assign head_hit = protect_head && !empty && (wr_ptr == rd_ptr);
  assign push     = push_req && !full && !head_hit;
  assign pop      = pop_req && !empty;

  // Storage is not reset; only pointers and occupancy say what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Occupancy moves only when exactly one of push/pop happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/in_port_ctrl.sv
// CPU input-port controller: buffers device words in a FIFO, gates the
// head word onto the CPU bus, tracks a hold FSM and a sticky underflow flag.
module in_port_ctrl #(
  parameter int DATA_W = in_port_pkg::DATA_W,
  parameter int DEPTH  = in_port_pkg::DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      dev_data,
  input  logic                   dev_valid,
  output logic                   dev_ready,
  input  logic                   InPortout,
  input  logic                   in_pop,
  input  logic                   clr_err,
  output logic [DATA_W-1:0]      bus_out,
  output logic                   in_empty,
  output logic                   in_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   underflow
);

  import in_port_pkg::*;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_HOLD = HOLD;

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [DATA_W-1:0] head_data;
  logic              underflow_event;

  assign dev_ready       = !in_full;
  assign underflow_event = in_pop && in_empty;
  assign bus_out         = (InPortout && !in_empty) ? head_data : '0;

  in_port_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_req     (dev_valid),
    .wr_data      (dev_data),
    .pop_req      (in_pop),
    .protect_head (state == ST_HOLD),
    .head_data    (head_data),
    .count        (count),
    .empty        (in_empty),
    .full         (in_full)
  );

  // Enter HOLD when the CPU starts reading; leave on consume or release.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (InPortout) state_next = ST_HOLD;
      ST_HOLD: if (in_pop || !InPortout) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sticky underflow: a new pop-while-empty takes priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow <= 1'b0;
    end else if (underflow_event) begin
      underflow <= 1'b1;
    end else if (clr_err) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: doc/in_port_ctrl.md
IN_PORT_CTRL -- requirements
Module: in_port_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the port and bus data width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (power of two).
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port dev_data, input, DATA_W, the external device word.
REQ-006 The block SHALL have port dev_valid, input, 1, asserted by the device when dev_data holds a word.
REQ-007 The block SHALL have port dev_ready, output, 1, indicating the block accepts a word this cycle.
REQ-008 The block SHALL have port InPortout, input, 1, the CPU control signal that drives the head word onto the bus.
REQ-009 The block SHALL have port in_pop, input, 1, the CPU strobe that consumes the head word (end of the "in" instruction).
REQ-010 The block SHALL have port clr_err, input, 1, a synchronous clear for the sticky error flag.
REQ-011 The block SHALL have port bus_out, output, DATA_W, the word contributed to the CPU bus multiplexer.
REQ-012 The block SHALL have port in_empty, output, 1, asserted when the FIFO holds no words.
REQ-013 The block SHALL have port in_full, output, 1, asserted when the FIFO holds DEPTH words.
REQ-014 The block SHALL have port count, output, log2(DEPTH)+1, the current occupancy.
REQ-015 The block SHALL have port underflow, output, 1, a sticky flag set by a pop while empty.

Function
REQ-016 dev_ready SHALL equal !in_full, combinationally.
REQ-017 A push SHALL occur on a rising clk edge when dev_valid && dev_ready; dev_data is written at the write pointer, and the pointer increments modulo DEPTH.
REQ-018 A pop SHALL occur on a rising clk edge when in_pop && !in_empty; the read pointer increments modulo DEPTH.
REQ-019 A simultaneous push and pop SHALL leave count unchanged and perform both pointer updates.
REQ-020 When the FIFO is full, dev_valid SHALL be ignored, with no write, no pointer change and no error.
REQ-021 in_pop while empty SHALL change no pointers and SHALL set underflow on the next edge.
REQ-022 underflow SHALL clear on the edge where clr_err=1 and no new underflow event occurs; a new event wins over clr_err.
REQ-023 bus_out SHALL equal the head entry when InPortout=1 and !in_empty; otherwise it SHALL equal 0. The path is combinational, so the word is visible in the same cycle.
REQ-024 A word pushed at edge N SHALL be visible on bus_out from edge N onward, giving a one-cycle latency from dev_valid to bus.
REQ-025 Occupancy SHALL be tracked with count, and in_full/in_empty SHALL be derived from count.
REQ-026 A two-state control FSM, IDLE/HOLD, SHALL exist:
  - IDLE goes to HOLD on the first cycle InPortout=1.
  - HOLD returns to IDLE on in_pop, or when InPortout deasserts.
  - While in HOLD, the head entry SHALL NOT be overwritten, even if a push targets its slot; this can only happen when the FIFO is full, so it is consistent with REQ-020.

Reset
REQ-027 On rst=0 the following SHALL be asynchronously cleared to 0: pointers, count, underflow and FSM state (IDLE).
REQ-028 At reset, outputs SHALL be: in_empty=1, in_full=0, dev_ready=1, bus_out=0.
REQ-029 Storage contents need not be reset.
REQ-030 Reset asserted mid-transfer SHALL discard all words; the first push after release is stored at entry 0.

Structure
REQ-031 A shared package in_port_pkg SHALL hold DATA_W, DEPTH, PTR_W=log2(DEPTH), and the FSM state enum {IDLE, HOLD}.
REQ-032 Storage and pointers SHALL live in a sub-module in_port_fifo; in_port_ctrl SHALL hold the FSM, the bus gating and the error flag.

Verification
REQ-033 After reset, push 32'hA5A5_0001, then assert InPortout -> bus_out=32'hA5A5_0001 in the same cycle; in_pop -> in_empty=1 and count=0.
REQ-034 Push 4 words (1,2,3,4) with dev_valid held for 5 cycles -> in_full=1 and dev_ready=0 after the 4th; the 5th word is not stored; pops return 1,2,3,4 in order.
REQ-035 Fill 3 words, then push and pop in the same cycle for 6 cycles -> count stays 3 and the pointers wrap with order preserved.
REQ-036 in_pop while empty -> underflow=1 on the next edge; clr_err with a simultaneous pop-while-empty -> underflow stays 1; clr_err alone -> underflow=0.
REQ-037 Push 2 words, then assert rst=0 mid-cycle -> count=0, in_empty=1 and bus_out=0 immediately; after release, push 32'h7 -> the head reads 32'h7.
REQ-038 With InPortout=0 and a non-empty FIFO -> bus_out=0.
